// File: rtl/sha3_burst_collector.sv
// Captures finished SHA3 states, tags digests with burst position and queues them on a FWFT valid/ready stream.
// Optional statistics counters are enabled by defining SHA3_COLLECTOR_STATS_EN.
module sha3_burst_collector #(
  parameter int BURST_LEN    = 16,
  parameter int DIGEST_LANES = 4,
  parameter int FIFO_DEPTH   = 32,
  localparam int IW = $clog2(BURST_LEN),
  localparam int DW = 64 * DIGEST_LANES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_good,
  input  logic [4:0][63:0]    ia,
  input  logic [4:0][63:0]    ib,
  input  logic [4:0][63:0]    ic,
  input  logic [4:0][63:0]    id,
  input  logic [4:0][63:0]    ie,
  output logic                space_ok,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_digest,
  output logic [IW-1:0]       out_index,
  output logic                out_last,
  output logic                overflow,
`ifdef SHA3_COLLECTOR_STATS_EN
  output logic [31:0]         burst_count,
  output logic [15:0]         drop_count,
`endif
  input  logic                clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DW + IW;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, count;
  logic [IW-1:0] idx;
  logic [DW-1:0] digest_in;
  logic [EW-1:0] head;
  logic          full, empty, rd_en, wr_en, drop, idx_last;

  // Only the leading lanes of row a carry the digest; the rest of the state is ignored.
  logic unused_rows;
  assign unused_rows = ^{ia, ib, ic, id, ie};

  always_comb begin
    digest_in = '0;
    for (int l = 0; l < DIGEST_LANES; l++) begin
      digest_in[64*l +: 64] = ia[l];
    end
  end

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign space_ok = (count <= PW'(FIFO_DEPTH - BURST_LEN));

  assign out_valid = !empty;
  assign rd_en     = out_valid && out_ready;
  assign wr_en     = in_good && (!full || rd_en);
  assign drop      = in_good && !wr_en;
  assign idx_last  = (idx == IW'(BURST_LEN - 1));

  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_digest = out_valid ? head[EW-1:IW] : '0;
  assign out_index  = out_valid ? head[IW-1:0] : '0;
  assign out_last   = out_valid && (head[IW-1:0] == IW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {digest_in, idx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      // Tags advance on every result, dropped or not, so they stay aligned to the core burst.
      if (in_good) idx <= idx_last ? '0 : idx + IW'(1);
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

`ifdef SHA3_COLLECTOR_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_count <= '0;
      drop_count  <= '0;
    end else begin
      if (in_good && idx_last) burst_count <= burst_count + 32'd1;
      if (clr_overflow)                    drop_count <= {15'd0, drop};
      else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha3_burst_collector.sv
// Scoreboard bench for sha3_burst_collector: per-cycle model of queue, index tags, overflow and space_ok.
module tb_sha3_burst_collector;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_good = 1'b0;
  logic [4:0][63:0] ia, ib, ic, id, ie;
  logic             space_ok, out_valid, out_last, overflow;
  logic             out_ready = 1'b0;
  logic             clr_overflow = 1'b0;
  logic [255:0]     out_digest;
  logic [3:0]       out_index;
`ifdef SHA3_COLLECTOR_STATS_EN
  logic [31:0]      burst_count;
  logic [15:0]      drop_count;
  int               m_burst = 0;
  int               m_drop = 0;
`endif

  typedef struct {
    logic [255:0] dig;
    logic [3:0]   idx;
  } ent_t;

  ent_t q[$];
  int   m_idx = 0;
  logic m_ovf = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  sha3_burst_collector dut (
    .clk(clk), .rst_n(rst_n), .in_good(in_good),
    .ia(ia), .ib(ib), .ic(ic), .id(id), .ie(ie),
    .space_ok(space_ok), .out_valid(out_valid), .out_ready(out_ready),
    .out_digest(out_digest), .out_index(out_index), .out_last(out_last),
    .overflow(overflow),
`ifdef SHA3_COLLECTOR_STATS_EN
    .burst_count(burst_count), .drop_count(drop_count),
`endif
    .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check head against the scoreboard, advance the model across the edge.
  task automatic cycle();
    logic         pop, wr, drop;
    logic [255:0] dig;
    ent_t         e;
    chk("valid", out_valid, q.size() != 0);
    pop = (q.size() != 0) && out_ready;
    if (pop) begin
      chk("digest", out_digest, q[0].dig);
      chk("index", out_index, q[0].idx);
      chk("last", out_last, q[0].idx == 4'd15);
    end
    wr   = in_good && (q.size() < 32 || pop);
    drop = in_good && !wr;
    for (int l = 0; l < 4; l++) dig[64*l +: 64] = ia[l];
    e.dig = dig;
    e.idx = 4'(m_idx);
`ifdef SHA3_COLLECTOR_STATS_EN
    if (in_good && m_idx == 15) m_burst++;
    if (clr_overflow) m_drop = drop ? 1 : 0;
    else if (drop && m_drop < 16'hFFFF) m_drop++;
`endif
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (wr) q.push_back(e);
    if (in_good) m_idx = (m_idx == 15) ? 0 : m_idx + 1;
    if (drop) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    chk("overflow", overflow, m_ovf);
    chk("space_ok", space_ok, (32 - q.size()) >= 16);
`ifdef SHA3_COLLECTOR_STATS_EN
    chk("burst_count", burst_count, m_burst);
    chk("drop_count", drop_count, m_drop);
`endif
  endtask

  task automatic randomize_rows();
    for (int l = 0; l < 5; l++) begin
      ia[l] = {$urandom, $urandom};
      ib[l] = {$urandom, $urandom};
      ic[l] = {$urandom, $urandom};
      id[l] = {$urandom, $urandom};
      ie[l] = {$urandom, $urandom};
    end
  endtask

  task automatic good();
    randomize_rows();
    in_good = 1'b1;
    cycle();
    in_good = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_good = 1'b0;
    out_ready = 1'b0;
    clr_overflow = 1'b0;
    #1;
    q.delete();
    m_idx = 0;
    m_ovf = 1'b0;
`ifdef SHA3_COLLECTOR_STATS_EN
    m_burst = 0;
    m_drop = 0;
    chk("rst_burst", burst_count, 0);
    chk("rst_drop", drop_count, 0);
`endif
    chk("rst_valid", out_valid, 0);
    chk("rst_space", space_ok, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_digest", out_digest, 0);
    chk("rst_index", out_index, 0);
    chk("rst_last", out_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (q.size() == 0) break;
      cycle();
    end
    chk("drained", q.size() == 0, 1);
    chk("drain_valid", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    randomize_rows();
    do_reset();

    // Single result into an empty FIFO
    randomize_rows();
    ia[0] = 64'h1;
    in_good = 1'b1;
    cycle();
    in_good = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_d0", out_digest[63:0], 64'h1);
    chk("t1_index", out_index, 0);
    drain();

    // Fill to full, then overflow, then full with simultaneous read
    do_reset();
    for (int i = 0; i < 16; i++) good();
    chk("space_16", space_ok, 1);
    good();
    chk("space_17", space_ok, 0);
    for (int i = 0; i < 16; i++) good();
    chk("full_ovf", overflow, 1);
    chk("full_head_idx", out_index, 0);
    chk("full_count", q.size(), 32);
    clr_overflow = 1'b1;
    cycle();
    clr_overflow = 1'b0;
    chk("clr_ovf", overflow, 0);
    out_ready = 1'b1;
    good();
    out_ready = 1'b0;
    chk("full_rw_valid", out_valid, 1);
    chk("full_rw_ovf", overflow, 0);
    clr_overflow = 1'b1;
    good();
    clr_overflow = 1'b0;
    chk("drop_beats_clr", overflow, 1);
    drain();

    // Four bursts with a feeder that honours space_ok and a random consumer
    do_reset();
    for (int b = 0; b < 4; b++) begin
      int waited = 0;
      while (!space_ok && waited < 300) begin
        out_ready = ($urandom_range(0, 3) != 0);
        cycle();
        waited++;
      end
      chk("space_wait", space_ok, 1);
      for (int i = 0; i < 16; i++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        good();
      end
    end
    drain();
    chk("rand_no_drop", overflow, 0);

    // Reset in the middle of a burst
    do_reset();
    for (int i = 0; i < 7; i++) good();
    chk("mid_valid", out_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    do_reset();
    good();
    chk("restart_index", out_index, 0);
    chk("restart_valid", out_valid, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
